// File: rtl/vec_seq_controller.sv
// vec_seq_controller: PC-owning fetch/execute controller with memory-ack stalls.
// Optional CTRL_BRANCH_NZ_EN makes op 1101 a branch-if-not-zero.
module vec_seq_controller #(
   parameter int WIDTH_INSTR  = 16,
   parameter int WIDTH_VECTOR = 8,
   parameter int WA_RF        = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic [WIDTH_VECTOR-1:0] pc,
   input  logic                    instr_valid,
   input  logic [WIDTH_INSTR-1:0]  instr,
   output logic                    instr_ready,
   output logic                    op_valid,
   output logic [3:0]              opcode,
   output logic [WA_RF-1:0]        addr_rega,
   output logic [WA_RF-1:0]        addr_regb,
   output logic [WIDTH_VECTOR-1:0] data_imm,
   output logic [WIDTH_VECTOR-1:0] we_rf,
   output logic                    we_mem,
   output logic                    mem_alu,
   input  logic                    mem_ack,
   input  logic                    zero,
   output logic                    jump,
   output logic                    halted
);
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEMWAIT, HALT} state_t;
   state_t state_q, state_d;
   logic [WIDTH_VECTOR-1:0] pc_q, pc_d;
   logic [WIDTH_INSTR-1:0] instr_q, instr_d;
   logic is_mem, is_halt, no_wr, take_br;
   assign opcode    = instr_q[WIDTH_INSTR-1 -: 4];
   assign addr_rega = instr_q[WIDTH_INSTR-5 -: WA_RF];
   assign addr_regb = instr_q[WIDTH_INSTR-5-WA_RF -: WA_RF];
   assign data_imm  = instr_q[WIDTH_VECTOR-1:0];
   assign is_mem    = opcode == 4'b1001 || opcode == 4'b1010;
   assign is_halt   = opcode == 4'b1111;
`ifdef CTRL_BRANCH_NZ_EN
   assign no_wr   = opcode inside {4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1111};
   assign take_br = (opcode == 4'b1100 && zero) || (opcode == 4'b1101 && !zero);
`else
   assign no_wr   = opcode inside {4'b1010, 4'b1011, 4'b1100, 4'b1111};
   assign take_br = opcode == 4'b1100 && zero;
`endif
   assign pc          = pc_q;
   assign instr_ready = state_q == FETCH;
   assign halted      = state_q == HALT;
   assign op_valid    = state_q == EXEC || state_q == MEMWAIT;
   assign mem_alu     = op_valid && is_mem;
   assign we_mem      = op_valid && opcode == 4'b1001;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      we_rf   = '0;
      jump    = 1'b0;
      case (state_q)
         IDLE:  state_d = start ? FETCH : IDLE;
         FETCH: if (instr_valid) begin
            instr_d = instr;
            state_d = EXEC;
         end
         EXEC: begin
            we_rf   = (is_mem || no_wr) ? '0 : data_imm;
            jump    = take_br;
            state_d = is_mem ? MEMWAIT : is_halt ? HALT : FETCH;
            pc_d    = (is_mem || is_halt) ? pc_q : take_br ? data_imm : pc_q + WIDTH_VECTOR'(1);
         end
         MEMWAIT: if (mem_ack) begin
            we_rf   = no_wr ? '0 : data_imm;
            pc_d    = pc_q + WIDTH_VECTOR'(1);
            state_d = FETCH;
         end
         HALT: if (start) begin
            pc_d    = '0;
            state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_vec_seq_controller.sv
// tb_vec_seq_controller: table-driven check of fetch/execute, plus mem, halt and reset sequences.
module tb_vec_seq_controller;
   logic clk = 0, rst = 1, start = 0, instr_valid = 0, mem_ack = 0, zero = 0;
   logic [15:0] instr = '0;
   logic [7:0] pc, data_imm, we_rf;
   logic [3:0] opcode, addr_rega, addr_regb;
   logic instr_ready, op_valid, we_mem, mem_alu, jump, halted;
   int total = 0, bad = 0;
   logic [7:0] epc;

   vec_seq_controller dut (
      .clk(clk), .rst(rst), .start(start), .pc(pc), .instr_valid(instr_valid),
      .instr(instr), .instr_ready(instr_ready), .op_valid(op_valid), .opcode(opcode),
      .addr_rega(addr_rega), .addr_regb(addr_regb), .data_imm(data_imm), .we_rf(we_rf),
      .we_mem(we_mem), .mem_alu(mem_alu), .mem_ack(mem_ack), .zero(zero), .jump(jump),
      .halted(halted));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ins;
      logic        z;
      logic [7:0]  we;
      logic        j;
      logic [7:0]  npc;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one instruction in FETCH; returns at the negedge inside its EXEC cycle.
   task automatic fetch(input logic [15:0] w, input logic z);
      int n = 0;
      while (!instr_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         total++;
         bad++;
         $display("FAIL fetch_timeout: instr_ready got 0 expected 1");
      end
      instr = w;
      zero = z;
      instr_valid = 1;
      @(negedge clk);
      instr_valid = 0;
      #1;
   endtask

   initial begin
      tbl[0] = '{16'h00A5, 1'b0, 8'hA5, 1'b0, 8'h01};
      tbl[1] = '{16'hC040, 1'b1, 8'h00, 1'b1, 8'h40};
      tbl[2] = '{16'hC010, 1'b0, 8'h00, 1'b0, 8'h41};
      tbl[3] = '{16'hB033, 1'b0, 8'h00, 1'b0, 8'h42};
`ifdef CTRL_BRANCH_NZ_EN
      tbl[4] = '{16'hD077, 1'b1, 8'h00, 1'b0, 8'h43};
`else
      tbl[4] = '{16'hD077, 1'b1, 8'h77, 1'b0, 8'h43};
`endif
      tbl[5] = '{16'hC0FF, 1'b1, 8'h00, 1'b1, 8'hFF};
      tbl[6] = '{16'h2312, 1'b0, 8'h12, 1'b0, 8'h00};
`ifdef CTRL_BRANCH_NZ_EN
      tbl[7] = '{16'hD022, 1'b0, 8'h00, 1'b1, 8'h22};
`else
      tbl[7] = '{16'hD022, 1'b0, 8'h22, 1'b0, 8'h01};
`endif
      #3;
      chk("rst_pc", pc, 0);
      chk("rst_ready", instr_ready, 0);
      chk("rst_opvalid", op_valid, 0);
      chk("rst_we_rf", we_rf, 0);
      chk("rst_halted", halted, 0);
      chk("rst_opcode", opcode, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("idle_ready", instr_ready, 0);
      start = 1;
      @(negedge clk);
      start = 0;
      chk("fetch_ready", instr_ready, 1);
      chk("fetch_pc", pc, 0);

      foreach (tbl[i]) begin
         fetch(tbl[i].ins, tbl[i].z);
         chk($sformatf("v%0d_opvalid", i), op_valid, 1);
         chk($sformatf("v%0d_ready_low", i), instr_ready, 0);
         chk($sformatf("v%0d_we_rf", i), we_rf, tbl[i].we);
         chk($sformatf("v%0d_jump", i), jump, tbl[i].j);
         chk($sformatf("v%0d_mem", i), {we_mem, mem_alu}, 0);
         chk($sformatf("v%0d_fields", i), {opcode, addr_rega, addr_regb, data_imm},
             {tbl[i].ins[15:12], tbl[i].ins[11:8], tbl[i].ins[7:4], tbl[i].ins[7:0]});
         @(negedge clk);
         chk($sformatf("v%0d_pc", i), pc, tbl[i].npc);
         chk($sformatf("v%0d_ready_back", i), instr_ready, 1);
         chk($sformatf("v%0d_jump_off", i), jump, 0);
      end
      epc = tbl[7].npc;

      // store with two silent MEMWAIT cycles then ack in the third
      fetch(16'h940F, 1'b0);
      for (int c = 0; c < 4; c++) begin
         if (c == 3) begin
            mem_ack = 1;
            #1;
         end
         chk($sformatf("st%0d_we_mem", c), we_mem, 1);
         chk($sformatf("st%0d_mem_alu", c), mem_alu, 1);
         chk($sformatf("st%0d_opvalid", c), op_valid, 1);
         chk($sformatf("st%0d_we_rf", c), we_rf, c == 3 ? 8'h0F : 8'h00);
         chk($sformatf("st%0d_pc", c), pc, epc);
         @(negedge clk);
      end
      mem_ack = 0;
      epc = epc + 8'd1;
      #1;
      chk("st_pc_after", pc, epc);
      chk("st_ready_after", instr_ready, 1);
      chk("st_we_mem_off", we_mem, 0);

      // load with ack in first MEMWAIT cycle; 1010 never writes RF
      fetch(16'hA0AA, 1'b0);
      chk("ld_we_mem", we_mem, 0);
      chk("ld_mem_alu", mem_alu, 1);
      @(negedge clk);
      mem_ack = 1;
      #1;
      chk("ld_ack_we_rf", we_rf, 0);
      chk("ld_ack_opvalid", op_valid, 1);
      @(negedge clk);
      mem_ack = 0;
      epc = epc + 8'd1;
      chk("ld_pc_after", pc, epc);
      chk("ld_ready_after", instr_ready, 1);

      // halt, ignore instr_valid, restart
      fetch(16'hF000, 1'b0);
      chk("hlt_exec_we_rf", we_rf, 0);
      @(negedge clk);
      chk("hlt_halted", halted, 1);
      chk("hlt_ready", instr_ready, 0);
      chk("hlt_pc", pc, epc);
      instr_valid = 1;
      instr = 16'h0011;
      @(negedge clk);
      @(negedge clk);
      instr_valid = 0;
      chk("hlt_still", halted, 1);
      chk("hlt_opvalid", op_valid, 0);
      start = 1;
      @(negedge clk);
      start = 0;
      chk("restart_pc", pc, 0);
      chk("restart_ready", instr_ready, 1);
      chk("restart_halted", halted, 0);

      // abandon a memory transfer with asynchronous reset
      fetch(16'h9455, 1'b0);
      @(negedge clk);
      chk("ab_memwait", we_mem, 1);
      rst = 1;
      #1;
      chk("ab_opvalid", op_valid, 0);
      chk("ab_we_mem", we_mem, 0);
      chk("ab_mem_alu", mem_alu, 0);
      chk("ab_pc", pc, 0);
      chk("ab_ready", instr_ready, 0);
      chk("ab_opcode", opcode, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("ab_idle", {instr_ready, halted}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
